// File: rtl/uart_bridge.sv
// CPU-to-UART chip bridge: maps a data and a status register onto the chip's
// active-low read/write strobes and shared 8-bit bus, with a 1-cycle ack.
module uart_bridge #(
    parameter logic [15:0] DATA_ADDR = 16'hBF00,
    parameter logic [15:0] STAT_ADDR = 16'hBF01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic [7:0]  uart_data_i,
    output logic [7:0]  uart_data_o,
    output logic        uart_data_oe,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre
);

    typedef enum logic [2:0] {
        IDLE, RD0, RD1, WR0, WR1, WAIT_TBRE, WAIT_TSRE, ACK
    } state_t;

    typedef struct packed {
        logic       rdn;
        logic       wrn;
        logic       oe;
        logic [7:0] dout;
    } chip_t;

    state_t      state, nxt;
    chip_t       chip_q, chip_d;
    logic        rdata_ld;
    logic [15:0] rdata_d;
    logic        is_data, is_stat;
    logic        unused_wdata;

    assign is_data      = (addr_i == DATA_ADDR);
    assign is_stat      = (addr_i == STAT_ADDR);
    assign unused_wdata = ^wdata_i[15:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req_i && !ack_o) begin
                    if (is_data) nxt = we_i ? WR0 : RD0;
                    else         nxt = ACK;
                end
            end
            RD0:       nxt = RD1;
            RD1:       nxt = ACK;
            WR0:       nxt = WR1;
            WR1:       nxt = WAIT_TBRE;
            WAIT_TBRE: if (tbre) nxt = WAIT_TSRE;
            WAIT_TSRE: if (tsre) nxt = ACK;
            ACK:       nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Chip-side strobes are decoded from the next state and registered, so
    // they are glitch-free and line up exactly with the state they belong to.
    always_comb begin
        ack_o       = (state == ACK);
        stall_o     = req_i & ~ack_o;
        chip_d.rdn  = ~(nxt == RD0 || nxt == RD1);
        chip_d.wrn  = ~(nxt == WR0);
        chip_d.oe   = (nxt == WR0 || nxt == WR1);
        chip_d.dout = chip_q.dout;
        if (state == IDLE && nxt == WR0) chip_d.dout = wdata_i[7:0];
        rdata_ld = (nxt == ACK);
        rdata_d  = 16'h0000;
        if (state == IDLE && !we_i && is_stat)
            rdata_d = {14'b0, data_ready, tbre & tsre};
        else if (state == RD1)
            rdata_d = {8'h00, uart_data_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chip_q  <= '{rdn: 1'b1, wrn: 1'b1, oe: 1'b0, dout: 8'h00};
            rdata_o <= 16'h0000;
        end else begin
            chip_q <= chip_d;
            if (rdata_ld) rdata_o <= rdata_d;
        end
    end

    assign uart_rdn     = chip_q.rdn;
    assign uart_wrn     = chip_q.wrn;
    assign uart_data_oe = chip_q.oe;
    assign uart_data_o  = chip_q.dout;

endmodule
